// File: rtl/mrv1_pkg.sv
// Shared types for the mrv1 operand collector: execute source selects,
// buffer occupancy encoding and the per-entry storage record.
package mrv1_pkg;

    // Field widths of a buffered entry; collector parameters must match these.
    localparam int unsigned Mrv1DataWidth    = 32;
    localparam int unsigned Mrv1TidWidth     = 2;
    localparam int unsigned Mrv1RegAddrWidth = 5;

    typedef enum logic [1:0] {
        Src0Rs0 = 2'd0,
        Src0Rs1 = 2'd1,
        Src0Pc  = 2'd2,
        Src0Imm = 2'd3
    } xrv_exe_src0_sel_e;

    // Encoding 3 is unused and falls back to rs0.
    typedef enum logic [1:0] {
        Src1Rs0 = 2'd0,
        Src1Rs1 = 2'd1,
        Src1Imm = 2'd2
    } xrv_exe_src1_sel_e;

    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccOne   = 2'd1,
        OccFull  = 2'd2
    } mrv1_src_occ_e;

    typedef struct packed {
        logic [Mrv1TidWidth-1:0]     tid;
        xrv_exe_src0_sel_e           src0_sel;
        xrv_exe_src1_sel_e           src1_sel;
        logic [Mrv1RegAddrWidth-1:0] rs0_addr;
        logic [Mrv1RegAddrWidth-1:0] rs1_addr;
        logic [Mrv1DataWidth-1:0]    rs0_data;
        logic [Mrv1DataWidth-1:0]    rs1_data;
        logic [Mrv1DataWidth-1:0]    imm0;
        logic [Mrv1DataWidth-1:0]    imm1;
        logic [Mrv1DataWidth-1:0]    pc;    // zero-extended instruction PC
    } mrv1_src_entry_t;

endpackage

// File: rtl/mrv1_fwd_match.sv
// Priority match of one (tid, register) pair against all writeback
// forwarding ports. Register x0 never matches; the highest-index port wins.
module mrv1_fwd_match #(
    parameter int unsigned TID_WIDTH_P      = 2,
    parameter int unsigned REG_ADDR_WIDTH_P = 5,
    parameter int unsigned DATA_WIDTH_P     = 32,
    parameter int unsigned FWD_PORTS_P      = 2
) (
    input  logic [TID_WIDTH_P-1:0]                  tid_i,
    input  logic [REG_ADDR_WIDTH_P-1:0]             addr_i,
    input  logic [FWD_PORTS_P-1:0]                  fwd_valid_i,
    input  logic [FWD_PORTS_P*TID_WIDTH_P-1:0]      fwd_tid_i,
    input  logic [FWD_PORTS_P*REG_ADDR_WIDTH_P-1:0] fwd_addr_i,
    input  logic [FWD_PORTS_P*DATA_WIDTH_P-1:0]     fwd_data_i,
    output logic                                    hit_o,
    output logic [DATA_WIDTH_P-1:0]                 data_o
);

    // Ascending scan so a later (higher) matching port overrides earlier ones.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int k = 0; k < FWD_PORTS_P; k++) begin
            if (fwd_valid_i[k] &&
                (fwd_tid_i[k*TID_WIDTH_P +: TID_WIDTH_P] == tid_i) &&
                (fwd_addr_i[k*REG_ADDR_WIDTH_P +: REG_ADDR_WIDTH_P] == addr_i) &&
                (addr_i != '0)) begin
                hit_o  = 1'b1;
                data_o = fwd_data_i[k*DATA_WIDTH_P +: DATA_WIDTH_P];
            end
        end
    end

endmodule

// File: rtl/mrv1_src_collect.sv
// Operand collector: 2-entry in-order buffer between issue and execute.
// Entry 0 is always the head. Define MRV1_SRC_FWD_EN to enable issue-time
// bypass and snooping of buffered operands from the writeback ports.
module mrv1_src_collect
    import mrv1_pkg::*;
#(
    parameter int unsigned PC_WIDTH_P       = 32,
    parameter int unsigned DATA_WIDTH_P     = Mrv1DataWidth,
    parameter int unsigned TID_WIDTH_P      = Mrv1TidWidth,
    parameter int unsigned REG_ADDR_WIDTH_P = Mrv1RegAddrWidth,
    parameter int unsigned FWD_PORTS_P      = 2
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    flush_i,
    input  logic                                    issue_valid_i,
    output logic                                    issue_ready_o,
    input  logic [TID_WIDTH_P-1:0]                  issue_tid_i,
    input  xrv_exe_src0_sel_e                       src0_sel_i,
    input  xrv_exe_src1_sel_e                       src1_sel_i,
    input  logic [REG_ADDR_WIDTH_P-1:0]             rs0_addr_i,
    input  logic [REG_ADDR_WIDTH_P-1:0]             rs1_addr_i,
    input  logic [DATA_WIDTH_P-1:0]                 rs0_data_i,
    input  logic [DATA_WIDTH_P-1:0]                 rs1_data_i,
    input  logic [DATA_WIDTH_P-1:0]                 insn_imm0_i,
    input  logic [DATA_WIDTH_P-1:0]                 insn_imm1_i,
    input  logic [PC_WIDTH_P-1:0]                   insn_pc_i,
    input  logic [FWD_PORTS_P-1:0]                  fwd_valid_i,
    input  logic [FWD_PORTS_P*TID_WIDTH_P-1:0]      fwd_tid_i,
    input  logic [FWD_PORTS_P*REG_ADDR_WIDTH_P-1:0] fwd_addr_i,
    input  logic [FWD_PORTS_P*DATA_WIDTH_P-1:0]     fwd_data_i,
    output logic                                    exe_valid_o,
    input  logic                                    exe_ready_i,
    output logic [TID_WIDTH_P-1:0]                  exe_tid_o,
    output logic [DATA_WIDTH_P-1:0]                 src0_data_o,
    output logic [DATA_WIDTH_P-1:0]                 src1_data_o,
    output logic [DATA_WIDTH_P-1:0]                 src2_data_o
);

    mrv1_src_occ_e   occ_q;
    mrv1_src_entry_t ent_q   [2];
    mrv1_src_entry_t ent_snp [2];
    mrv1_src_entry_t ent_in;
    logic            exe_valid_q;
    logic            issue_ready_q;
    logic            push;
    logic            pop;

    logic [DATA_WIDTH_P-1:0] in_rs0;
    logic [DATA_WIDTH_P-1:0] in_rs1;
    logic [DATA_WIDTH_P-1:0] snp_rs0 [2];
    logic [DATA_WIDTH_P-1:0] snp_rs1 [2];

    assign issue_ready_o = issue_ready_q;
    assign exe_valid_o   = exe_valid_q;
    assign push          = issue_valid_i && issue_ready_q;
    assign pop           = exe_valid_q && exe_ready_i;

`ifdef MRV1_SRC_FWD_EN
    logic                    in_hit0;
    logic                    in_hit1;
    logic [DATA_WIDTH_P-1:0] in_fwd0;
    logic [DATA_WIDTH_P-1:0] in_fwd1;

    mrv1_fwd_match #(
        .TID_WIDTH_P      (TID_WIDTH_P),
        .REG_ADDR_WIDTH_P (REG_ADDR_WIDTH_P),
        .DATA_WIDTH_P     (DATA_WIDTH_P),
        .FWD_PORTS_P      (FWD_PORTS_P)
    ) u_in_rs0 (
        .tid_i       (issue_tid_i),
        .addr_i      (rs0_addr_i),
        .fwd_valid_i (fwd_valid_i),
        .fwd_tid_i   (fwd_tid_i),
        .fwd_addr_i  (fwd_addr_i),
        .fwd_data_i  (fwd_data_i),
        .hit_o       (in_hit0),
        .data_o      (in_fwd0)
    );

    mrv1_fwd_match #(
        .TID_WIDTH_P      (TID_WIDTH_P),
        .REG_ADDR_WIDTH_P (REG_ADDR_WIDTH_P),
        .DATA_WIDTH_P     (DATA_WIDTH_P),
        .FWD_PORTS_P      (FWD_PORTS_P)
    ) u_in_rs1 (
        .tid_i       (issue_tid_i),
        .addr_i      (rs1_addr_i),
        .fwd_valid_i (fwd_valid_i),
        .fwd_tid_i   (fwd_tid_i),
        .fwd_addr_i  (fwd_addr_i),
        .fwd_data_i  (fwd_data_i),
        .hit_o       (in_hit1),
        .data_o      (in_fwd1)
    );

    assign in_rs0 = in_hit0 ? in_fwd0 : rs0_data_i;
    assign in_rs1 = in_hit1 ? in_fwd1 : rs1_data_i;

    for (genvar i = 0; i < 2; i++) begin : g_ent_snoop
        logic                    hit0;
        logic                    hit1;
        logic [DATA_WIDTH_P-1:0] fwd0;
        logic [DATA_WIDTH_P-1:0] fwd1;

        mrv1_fwd_match #(
            .TID_WIDTH_P      (TID_WIDTH_P),
            .REG_ADDR_WIDTH_P (REG_ADDR_WIDTH_P),
            .DATA_WIDTH_P     (DATA_WIDTH_P),
            .FWD_PORTS_P      (FWD_PORTS_P)
        ) u_rs0 (
            .tid_i       (ent_q[i].tid),
            .addr_i      (ent_q[i].rs0_addr),
            .fwd_valid_i (fwd_valid_i),
            .fwd_tid_i   (fwd_tid_i),
            .fwd_addr_i  (fwd_addr_i),
            .fwd_data_i  (fwd_data_i),
            .hit_o       (hit0),
            .data_o      (fwd0)
        );

        mrv1_fwd_match #(
            .TID_WIDTH_P      (TID_WIDTH_P),
            .REG_ADDR_WIDTH_P (REG_ADDR_WIDTH_P),
            .DATA_WIDTH_P     (DATA_WIDTH_P),
            .FWD_PORTS_P      (FWD_PORTS_P)
        ) u_rs1 (
            .tid_i       (ent_q[i].tid),
            .addr_i      (ent_q[i].rs1_addr),
            .fwd_valid_i (fwd_valid_i),
            .fwd_tid_i   (fwd_tid_i),
            .fwd_addr_i  (fwd_addr_i),
            .fwd_data_i  (fwd_data_i),
            .hit_o       (hit1),
            .data_o      (fwd1)
        );

        assign snp_rs0[i] = hit0 ? fwd0 : ent_q[i].rs0_data;
        assign snp_rs1[i] = hit1 ? fwd1 : ent_q[i].rs1_data;
    end
`else
    // Forwarding disabled: operands keep their register-file values.
    logic unused_fwd;
    assign unused_fwd = ^{fwd_valid_i, fwd_tid_i, fwd_addr_i, fwd_data_i};
    assign in_rs0     = rs0_data_i;
    assign in_rs1     = rs1_data_i;
    for (genvar i = 0; i < 2; i++) begin : g_ent_hold
        assign snp_rs0[i] = ent_q[i].rs0_data;
        assign snp_rs1[i] = ent_q[i].rs1_data;
    end
`endif

    // Assemble the incoming entry and the snooped view of each stored entry.
    always_comb begin
        ent_in.tid      = issue_tid_i;
        ent_in.src0_sel = src0_sel_i;
        ent_in.src1_sel = src1_sel_i;
        ent_in.rs0_addr = rs0_addr_i;
        ent_in.rs1_addr = rs1_addr_i;
        ent_in.rs0_data = in_rs0;
        ent_in.rs1_data = in_rs1;
        ent_in.imm0     = insn_imm0_i;
        ent_in.imm1     = insn_imm1_i;
        ent_in.pc       = DATA_WIDTH_P'(insn_pc_i);
        for (int i = 0; i < 2; i++) begin
            ent_snp[i]          = ent_q[i];
            ent_snp[i].rs0_data = snp_rs0[i];
            ent_snp[i].rs1_data = snp_rs1[i];
        end
    end

    // Occupancy FSM with registered handshake outputs; only valid entries snoop.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            occ_q         <= OccEmpty;
            exe_valid_q   <= 1'b0;
            issue_ready_q <= 1'b1;
            ent_q[0]      <= '0;
            ent_q[1]      <= '0;
        end else if (flush_i) begin
            occ_q         <= OccEmpty;
            exe_valid_q   <= 1'b0;
            issue_ready_q <= 1'b1;
        end else begin
            unique case (occ_q)
                OccEmpty: begin
                    if (push) begin
                        ent_q[0]      <= ent_in;
                        occ_q         <= OccOne;
                        exe_valid_q   <= 1'b1;
                    end
                end
                OccOne: begin
                    if (pop) begin
                        if (push) begin
                            ent_q[0] <= ent_in;
                        end else begin
                            occ_q       <= OccEmpty;
                            exe_valid_q <= 1'b0;
                        end
                    end else begin
                        ent_q[0] <= ent_snp[0];
                        if (push) begin
                            ent_q[1]      <= ent_in;
                            occ_q         <= OccFull;
                            issue_ready_q <= 1'b0;
                        end
                    end
                end
                OccFull: begin
                    if (pop) begin
                        ent_q[0]      <= ent_snp[1];
                        occ_q         <= OccOne;
                        issue_ready_q <= 1'b1;
                    end else begin
                        ent_q[0] <= ent_snp[0];
                        ent_q[1] <= ent_snp[1];
                    end
                end
                default: begin
                    occ_q         <= OccEmpty;
                    exe_valid_q   <= 1'b0;
                    issue_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Operand selection from the head entry.
    always_comb begin
        exe_tid_o   = ent_q[0].tid;
        src2_data_o = ent_q[0].rs1_data;
        case (ent_q[0].src0_sel)
            Src0Rs1: src0_data_o = ent_q[0].rs1_data;
            Src0Pc:  src0_data_o = ent_q[0].pc;
            Src0Imm: src0_data_o = ent_q[0].imm0;
            default: src0_data_o = ent_q[0].rs0_data;
        endcase
        case (ent_q[0].src1_sel)
            Src1Rs1: src1_data_o = ent_q[0].rs1_data;
            Src1Imm: src1_data_o = ent_q[0].imm1;
            default: src1_data_o = ent_q[0].rs0_data;
        endcase
    end

endmodule

// File: tb/tb_mrv1_src_collect.sv
// Directed bench for mrv1_src_collect (expectations follow MRV1_SRC_FWD_EN).
module tb_mrv1_src_collect;
    import mrv1_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              flush_i;
    logic              issue_valid_i;
    logic              issue_ready_o;
    logic [1:0]        issue_tid_i;
    xrv_exe_src0_sel_e src0_sel_i;
    xrv_exe_src1_sel_e src1_sel_i;
    logic [4:0]        rs0_addr_i;
    logic [4:0]        rs1_addr_i;
    logic [31:0]       rs0_data_i;
    logic [31:0]       rs1_data_i;
    logic [31:0]       insn_imm0_i;
    logic [31:0]       insn_imm1_i;
    logic [31:0]       insn_pc_i;
    logic [1:0]        fwd_valid_i;
    logic [3:0]        fwd_tid_i;
    logic [9:0]        fwd_addr_i;
    logic [63:0]       fwd_data_i;
    logic              exe_valid_o;
    logic              exe_ready_i;
    logic [1:0]        exe_tid_o;
    logic [31:0]       src0_data_o;
    logic [31:0]       src1_data_o;
    logic [31:0]       src2_data_o;

    int checks = 0;
    int errors = 0;

`ifdef MRV1_SRC_FWD_EN
    localparam logic Fwd = 1'b1;
`else
    localparam logic Fwd = 1'b0;
`endif

    mrv1_src_collect dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .issue_valid_i (issue_valid_i),
        .issue_ready_o (issue_ready_o),
        .issue_tid_i   (issue_tid_i),
        .src0_sel_i    (src0_sel_i),
        .src1_sel_i    (src1_sel_i),
        .rs0_addr_i    (rs0_addr_i),
        .rs1_addr_i    (rs1_addr_i),
        .rs0_data_i    (rs0_data_i),
        .rs1_data_i    (rs1_data_i),
        .insn_imm0_i   (insn_imm0_i),
        .insn_imm1_i   (insn_imm1_i),
        .insn_pc_i     (insn_pc_i),
        .fwd_valid_i   (fwd_valid_i),
        .fwd_tid_i     (fwd_tid_i),
        .fwd_addr_i    (fwd_addr_i),
        .fwd_data_i    (fwd_data_i),
        .exe_valid_o   (exe_valid_o),
        .exe_ready_i   (exe_ready_i),
        .exe_tid_o     (exe_tid_o),
        .src0_data_o   (src0_data_o),
        .src1_data_o   (src1_data_o),
        .src2_data_o   (src2_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present an rs0-sourced instruction on the issue port.
    task automatic issue_rs0(input logic [1:0] tid, input logic [4:0] a, input logic [31:0] d);
        issue_valid_i = 1'b1;
        issue_tid_i   = tid;
        src0_sel_i    = Src0Rs0;
        src1_sel_i    = Src1Rs1;
        rs0_addr_i    = a;
        rs0_data_i    = d;
        rs1_addr_i    = 5'd0;
        rs1_data_i    = 32'h0;
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; issue_valid_i = 1'b0; issue_tid_i = '0;
        src0_sel_i = Src0Rs0; src1_sel_i = Src1Rs0; rs0_addr_i = '0; rs1_addr_i = '0;
        rs0_data_i = '0; rs1_data_i = '0; insn_imm0_i = '0; insn_imm1_i = '0;
        insn_pc_i = '0; fwd_valid_i = '0; fwd_tid_i = '0; fwd_addr_i = '0;
        fwd_data_i = '0; exe_ready_i = 1'b0;
        tick(); tick();
        chk("rst_exe_valid", 32'(exe_valid_o), 32'd0);
        chk("rst_issue_ready", 32'(issue_ready_o), 32'd1);
        chk("rst_tid", 32'(exe_tid_o), 32'd0);
        chk("rst_src0", src0_data_o, 32'h0);
        chk("rst_src1", src1_data_o, 32'h0);
        chk("rst_src2", src2_data_o, 32'h0);
        rst_ni = 1'b1;
        tick();

        // PC / IMM selection, one-cycle latency.
        issue_valid_i = 1'b1; issue_tid_i = 2'd1; src0_sel_i = Src0Pc; src1_sel_i = Src1Imm;
        insn_pc_i = 32'h100; insn_imm1_i = 32'h8; insn_imm0_i = 32'h44;
        rs1_data_i = 32'h33; exe_ready_i = 1'b1;
        tick();
        issue_valid_i = 1'b0;
        chk("pc_exe_valid", 32'(exe_valid_o), 32'd1);
        chk("pc_tid", 32'(exe_tid_o), 32'd1);
        chk("pc_src0", src0_data_o, 32'h100);
        chk("pc_src1", src1_data_o, 32'h8);
        chk("pc_src2", src2_data_o, 32'h33);
        tick();
        chk("pc_drained", 32'(exe_valid_o), 32'd0);

        // IMM on src0, then back-to-back issue at full throughput.
        issue_valid_i = 1'b1; src0_sel_i = Src0Imm; src1_sel_i = Src1Rs0;
        rs0_data_i = 32'h77;
        tick();
        chk("imm0_src0", src0_data_o, 32'h44);
        chk("imm0_src1_rs0", src1_data_o, 32'h77);
        issue_rs0(2'd3, 5'd9, 32'h5A5A);
        tick();
        issue_valid_i = 1'b0;
        chk("b2b_valid", 32'(exe_valid_o), 32'd1);
        chk("b2b_src0", src0_data_o, 32'h5A5A);
        chk("b2b_tid", 32'(exe_tid_o), 32'd3);
        tick();
        chk("b2b_drained", 32'(exe_valid_o), 32'd0);

        // Fill under back-pressure, reject while full, then drain in order.
        exe_ready_i = 1'b0;
        issue_rs0(2'd0, 5'd1, 32'hA1);
        tick();
        issue_rs0(2'd0, 5'd2, 32'hB2);
        tick();
        chk("full_issue_ready", 32'(issue_ready_o), 32'd0);
        chk("full_head", src0_data_o, 32'hA1);
        issue_rs0(2'd0, 5'd3, 32'hC3);
        tick();
        issue_valid_i = 1'b0;
        chk("full_hold", src0_data_o, 32'hA1);
        exe_ready_i = 1'b1;
        tick();
        chk("pop1_head", src0_data_o, 32'hB2);
        chk("pop1_issue_ready", 32'(issue_ready_o), 32'd1);
        chk("pop1_valid", 32'(exe_valid_o), 32'd1);
        tick();
        chk("pop2_empty", 32'(exe_valid_o), 32'd0);

        // Snoop on a stalled head.
        exe_ready_i = 1'b0;
        issue_rs0(2'd2, 5'd5, 32'h11);
        tick();
        issue_valid_i = 1'b0;
        chk("snp_init", src0_data_o, 32'h11);
        fwd_valid_i = 2'b01; fwd_tid_i = {2'd0, 2'd3}; fwd_addr_i = {5'd0, 5'd5};
        fwd_data_i = {32'h0, 32'hAA};
        tick();
        chk("snp_wrong_tid", src0_data_o, 32'h11);
        fwd_tid_i = {2'd0, 2'd2};
        tick();
        fwd_valid_i = 2'b00;
        chk("snp_hit", src0_data_o, Fwd ? 32'hAA : 32'h11);
        tick();
        chk("snp_sticky", src0_data_o, Fwd ? 32'hAA : 32'h11);
        exe_ready_i = 1'b1;
        tick();
        exe_ready_i = 1'b0;
        issue_rs0(2'd2, 5'd0, 32'h22);
        tick();
        issue_valid_i = 1'b0;
        fwd_valid_i = 2'b01; fwd_tid_i = {2'd0, 2'd2}; fwd_addr_i = {5'd0, 5'd0};
        fwd_data_i = {32'h0, 32'h55};
        tick();
        fwd_valid_i = 2'b00;
        chk("snp_x0", src0_data_o, 32'h22);
        exe_ready_i = 1'b1;
        tick();

        // Issue-time bypass with two matching ports: highest index wins.
        issue_rs0(2'd1, 5'd0, 32'h0);
        rs1_addr_i = 5'd7; rs1_data_i = 32'h99;
        fwd_valid_i = 2'b11; fwd_tid_i = {2'd1, 2'd1}; fwd_addr_i = {5'd7, 5'd7};
        fwd_data_i = {32'h2, 32'h1};
        tick();
        issue_valid_i = 1'b0; fwd_valid_i = 2'b00;
        chk("byp_src2", src2_data_o, Fwd ? 32'h2 : 32'h99);
        tick();

        // Flush while full with a concurrent issue.
        exe_ready_i = 1'b0;
        issue_rs0(2'd0, 5'd1, 32'hD1);
        tick();
        issue_rs0(2'd0, 5'd1, 32'hD2);
        tick();
        issue_rs0(2'd0, 5'd1, 32'hEE);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0; issue_valid_i = 1'b0;
        chk("flush_full_valid", 32'(exe_valid_o), 32'd0);
        chk("flush_full_ready", 32'(issue_ready_o), 32'd1);
        tick();
        chk("flush_full_gone", 32'(exe_valid_o), 32'd0);

        // Flush with one entry and an accepted-looking concurrent issue.
        issue_rs0(2'd0, 5'd1, 32'hD3);
        tick();
        issue_rs0(2'd0, 5'd1, 32'hEF);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0; issue_valid_i = 1'b0;
        chk("flush_one_valid", 32'(exe_valid_o), 32'd0);
        tick();
        chk("flush_one_gone", 32'(exe_valid_o), 32'd0);
        issue_rs0(2'd0, 5'd1, 32'hF0);
        tick();
        issue_valid_i = 1'b0;
        chk("post_flush_src0", src0_data_o, 32'hF0);
        chk("post_flush_valid", 32'(exe_valid_o), 32'd1);

        // Reset mid-operation clears everything.
        issue_rs0(2'd3, 5'd4, 32'h1234);
        tick();
        issue_valid_i = 1'b0;
        rst_ni = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(exe_valid_o), 32'd0);
        chk("mid_rst_ready", 32'(issue_ready_o), 32'd1);
        chk("mid_rst_tid", 32'(exe_tid_o), 32'd0);
        chk("mid_rst_src0", src0_data_o, 32'h0);
        rst_ni = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mrv1_src_collect.md
# mrv1_src_collect

Operand collector between issue and execute in the multithreaded core. It captures an issued instruction's register-file read data, immediates and PC into a 2-entry buffer and keeps buffered register operands current by snooping writeback forwarding ports. It presents the head entry's selected src0/src1/src2 operands to execute under a valid/ready handshake, so execute back-pressure no longer stalls on stale operands.

## Interface
- PC_WIDTH_P, 32, instruction PC width; must be ≤ DATA_WIDTH_P
- DATA_WIDTH_P, 32, operand width
- TID_WIDTH_P, 2, hardware thread ID width
- REG_ADDR_WIDTH_P, 5, architectural register address width
- FWD_PORTS_P, 2, number of writeback forwarding ports (≥1)

- clk_i  in  1  clock; one clock domain
- rst_ni  in  1  reset; synchronous, active-low
- flush_i  in  1  drop all buffered entries
- issue_valid_i / issue_ready_o  in/out  1  issue handshake
- issue_tid_i  in  TID_WIDTH_P  thread of the issued instruction
- src0_sel_i  in  xrv_exe_src0_sel_e  RS0/RS1/PC/IMM
- src1_sel_i  in  xrv_exe_src1_sel_e  RS0/RS1/IMM
- rs0_addr_i, rs1_addr_i  in  REG_ADDR_WIDTH_P  source register numbers
- rs0_data_i, rs1_data_i  in  DATA_WIDTH_P  register-file read data, valid with issue
- insn_imm0_i, insn_imm1_i  in  DATA_WIDTH_P  immediates
- insn_pc_i  in  PC_WIDTH_P  instruction PC
- fwd_valid_i  in  FWD_PORTS_P  per-port writeback valid
- fwd_tid_i  in  FWD_PORTS_P×TID_WIDTH_P  writeback thread
- fwd_addr_i  in  FWD_PORTS_P×REG_ADDR_WIDTH_P  writeback register
- fwd_data_i  in  FWD_PORTS_P×DATA_WIDTH_P  writeback data
- exe_valid_o / exe_ready_i  out/in  1  execute handshake
- exe_tid_o  out  TID_WIDTH_P  head entry thread
- src0_data_o, src1_data_o, src2_data_o  out  DATA_WIDTH_P  head entry operands

## Operation
- Two-entry in-order FIFO; occupancy states EMPTY(0), ONE(1), FULL(2).
- Push on issue_valid_i && issue_ready_o. Pop on exe_valid_o && exe_ready_i.
- Each entry stores tid, selects, rs0/rs1 addresses and values, imm0, imm1, and PC zero-extended to DATA_WIDTH_P.
- Forward match: fwd_valid_i[k], fwd_tid_i[k]==tid, fwd_addr_i[k]==rs addr, and addr≠0. If several ports match, the highest index wins.
- On push, a matching forward port replaces rs_data_i in the captured value (same-cycle bypass).
- Every cycle, each valid entry's rs0/rs1 value is overwritten by a matching forward port (snoop). This includes the head entry while it is stalled.
- Output mux on the head entry:
  - src0: RS0→rs0, RS1→rs1, PC→pc, IMM→imm0, other→rs0.
  - src1: RS0→rs0, RS1→rs1, IMM→imm1, other→rs0.
  - src2 = rs1 always.
- Simultaneous push and pop in ONE: occupancy stays ONE and the new entry becomes head next cycle.
- flush_i: occupancy→EMPTY next cycle. A same-cycle push is discarded and a same-cycle pop has no further effect. Flush has priority over push, pop and snoop.

## Timing
- Issue→exe_valid_o latency is 1 cycle. Throughput is 1 per cycle while exe_ready_i is high.
- issue_ready_o = (occupancy≠FULL), from registered state only. It has no combinational path from exe_ready_i.
- exe_valid_o = (occupancy≠EMPTY), registered.
- Head fields hold stable while exe_valid_o && !exe_ready_i, except for snoop updates.
- A snoop update is visible on src*_data_o the cycle after the forward port asserts.
- Reset (rst_ni low at a clk_i edge, including mid-operation): occupancy EMPTY, exe_valid_o=0, issue_ready_o=1, all entry storage 0. Therefore exe_tid_o=0 and src0/1/2_data_o=0.

## Configuration
- MRV1_SRC_FWD_EN defined: issue-time bypass and buffer snooping as described.
- MRV1_SRC_FWD_EN undefined: fwd_* ports remain but are ignored, and operands hold the values captured from rs*_data_i. Matching logic is not synthesised.

## Structure
- mrv1_pkg holds xrv_exe_src0_sel_e, xrv_exe_src1_sel_e and a new mrv1_src_entry_t struct with the per-entry fields.
- Sub-module mrv1_fwd_match: combinational priority match of one (tid, addr, value) against all forward ports. It returns the hit flag and the selected data.
- Instantiate mrv1_fwd_match once per operand per entry, plus once per incoming operand.

## Test plan
- Reset then issue tid=1, src0_sel=PC, pc=0x100, src1_sel=IMM, imm1=0x8, exe_ready=1 → next cycle exe_valid=1, src0=0x100, src1=0x8.
- Fill 2 entries with exe_ready=0 → issue_ready=0. Then exe_ready=1 → pops in order with no loss, and issue_ready=1 after the first pop.
- Stalled head tid=2, rs0=x5 old 0x11. Pulse fwd port 0 with tid=2, x5, 0xAA → src0 becomes 0xAA the next cycle. The same write with tid=3 or to x0 leaves it unchanged.
- Push with ports 0 and 1 both matching rs1 (0x1, 0x2) → src2=0x2.
- flush_i while FULL with a concurrent issue → exe_valid=0 next cycle and the issued instruction never appears.
- MRV1_SRC_FWD_EN undefined, rerun the snoop scenario → src0 remains 0x11.
